// File: rtl/fighter_pkg.sv
// fighter_pkg: shared combat geometry, damage constants, state encodings and damage helpers.
package fighter_pkg;
  localparam int BOX_W          = 60;
  localparam int BOX_H          = 60;
  localparam int ATK1_RANGE     = 30;
  localparam int ATK2_RANGE     = 60;
  localparam int ATK1_DMG       = 5;
  localparam int ATK2_DMG       = 10;
  localparam int HEALTH_MAX     = 100;
  localparam int HITSTUN_FRAMES = 20;
  localparam int STUN_W         = $clog2(HITSTUN_FRAMES);
  localparam logic [1:0] ATK_NONE = 2'd0;
  localparam logic [1:0] ATK1     = 2'd1;
  localparam logic [1:0] ATK2     = 2'd2;
  typedef enum logic [1:0] {P_ACTIVE, P_HITSTUN, P_KO} pstate_t;
  typedef enum logic {R_FIGHT, R_OVER} rstate_t;
  function automatic logic [6:0] sat_sub(input logic [6:0] h, input logic [6:0] d);
    return (h > d) ? h - d : 7'd0;
  endfunction
  function automatic logic [6:0] atk_dmg(input logic [1:0] t, input logic blocked);
    logic [6:0] d;
    d = (t == ATK2) ? 7'(ATK2_DMG) : 7'(ATK1_DMG);
    return blocked ? (((d >> 2) == 7'd0) ? 7'd1 : d >> 2) : d;
  endfunction
endpackage

// File: rtl/combat_hit_detect.sv
// combat_hit_detect: combinational attack hitbox vs opponent hurtbox intersection test.
module combat_hit_detect
  import fighter_pkg::*;
(
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic       facing_right,
  input  logic       active,
  input  logic [1:0] atk_type,
  input  logic [9:0] ox,
  input  logic [9:0] oy,
  output logic       hit
);
  logic [10:0] r, lo, hi, dy, ax11, ox11;
  always_comb begin
    ax11 = {1'b0, ax};
    ox11 = {1'b0, ox};
    r    = (atk_type == ATK2) ? 11'(ATK2_RANGE) : 11'(ATK1_RANGE);
    lo   = facing_right ? ax11 + 11'(BOX_W) : ((ax11 < r) ? 11'd0 : ax11 - r);
    hi   = facing_right ? lo + r : ax11;
    dy   = (ay > oy) ? 11'(ay - oy) : 11'(oy - ay);
    hit  = active && (atk_type == ATK1 || atk_type == ATK2) &&
           lo < ox11 + 11'(BOX_W) && ox11 < hi && dy < 11'(BOX_H);
  end
endmodule

// File: rtl/combat_arbiter.sv
// combat_arbiter: per-frame hit resolution, health/hitstun tracking and round control.
// Define COMBAT_BLOCK_EN to let a facing, blocking defender take chip damage instead of a hit.
module combat_arbiter
  import fighter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       round_restart,
  input  logic [9:0] p1_x,
  input  logic [9:0] p2_x,
  input  logic [9:0] p1_y,
  input  logic [9:0] p2_y,
  input  logic       p1_facing_right,
  input  logic       p2_facing_right,
  input  logic       p1_attack_active,
  input  logic       p2_attack_active,
  input  logic [1:0] p1_attack_type,
  input  logic [1:0] p2_attack_type,
  input  logic       p1_block,
  input  logic       p2_block,
  output logic       p1_move_en,
  output logic       p2_move_en,
  output logic       p1_attack_en,
  output logic       p2_attack_en,
  output logic [6:0] p1_health,
  output logic [6:0] p2_health,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       round_over,
  output logic [1:0] winner
);
  logic [1:0] act, det, valid, blk_req, blk, stun_hit, done, done_n, me, me_n, ae, ae_n, hit, win, win_n;
  logic [1:0][1:0] typ;
  logic [1:0][6:0] hp, hp_n;
  logic [1:0][STUN_W-1:0] cnt, cnt_n;
  pstate_t st [2], st_n [2];
  rstate_t rs, rs_n;
  logic restart, over_n;
  assign act = {p2_attack_active, p1_attack_active};
  assign typ = {p2_attack_type, p1_attack_type};
`ifdef COMBAT_BLOCK_EN
  assign blk_req = {p2_block, p1_block};
  assign blk = {p2_block && (p2_facing_right ? p1_x > p2_x : p1_x < p2_x),
                p1_block && (p1_facing_right ? p2_x > p1_x : p2_x < p1_x)};
`else
  logic unused_block;
  assign unused_block = p1_block ^ p2_block;
  assign blk_req = '0;
  assign blk = '0;
`endif
  combat_hit_detect u_p1_on_p2 (.ax(p1_x), .ay(p1_y), .facing_right(p1_facing_right), .active(p1_attack_active),
                                .atk_type(p1_attack_type), .ox(p2_x), .oy(p2_y), .hit(det[0]));
  combat_hit_detect u_p2_on_p1 (.ax(p2_x), .ay(p2_y), .facing_right(p2_facing_right), .active(p2_attack_active),
                                .atk_type(p2_attack_type), .ox(p1_x), .oy(p1_y), .hit(det[1]));
  // index d is the attacker in the first loop and the defender in the second
  always_comb begin
    restart = rs == R_OVER && round_restart;
    for (int d = 0; d < 2; d++) begin
      valid[d]  = det[d] && rs == R_FIGHT && st[d] == P_ACTIVE && st[1-d] == P_ACTIVE && !done[d];
      done_n[d] = act[d] && (done[d] || valid[d]);
    end
    for (int d = 0; d < 2; d++) begin
      hp_n[d]     = valid[1-d] ? sat_sub(hp[d], atk_dmg(typ[1-d], blk[d])) : hp[d];
      stun_hit[d] = valid[1-d] && !blk[d];
      st_n[d]     = (hp_n[d] == 7'd0) ? P_KO : stun_hit[d] ? P_HITSTUN :
                    (st[d] == P_HITSTUN && cnt[d] == '0) ? P_ACTIVE : st[d];
      cnt_n[d]    = stun_hit[d] ? STUN_W'(HITSTUN_FRAMES - 1) :
                    (st[d] == P_HITSTUN && cnt[d] != '0) ? cnt[d] - 1'b1 : cnt[d];
    end
    over_n = hp_n[0] == 7'd0 || hp_n[1] == 7'd0;
    win_n  = {hp_n[0] == 7'd0, hp_n[1] == 7'd0};
    rs_n   = over_n ? R_OVER : R_FIGHT;
    for (int d = 0; d < 2; d++) begin
      ae_n[d] = !over_n && st_n[d] == P_ACTIVE;
      me_n[d] = ae_n[d] && !blk_req[d];
    end
    if (restart) begin
      hp_n   = {7'(HEALTH_MAX), 7'(HEALTH_MAX)};
      st_n   = '{P_ACTIVE, P_ACTIVE};
      cnt_n  = '0;
      done_n = '0;
      rs_n   = R_FIGHT;
      win_n  = '0;
      me_n   = '1;
      ae_n   = '1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hp   <= {7'(HEALTH_MAX), 7'(HEALTH_MAX)};
      st   <= '{P_ACTIVE, P_ACTIVE};
      cnt  <= '0;
      done <= '0;
      rs   <= R_FIGHT;
      win  <= '0;
      me   <= '1;
      ae   <= '1;
      hit  <= '0;
    end else begin
      hit <= SCEN ? stun_hit : 2'b00;
      if (SCEN && (rs == R_FIGHT || restart)) begin
        hp   <= hp_n;
        st   <= st_n;
        cnt  <= cnt_n;
        done <= done_n;
        rs   <= rs_n;
        win  <= win_n;
        me   <= me_n;
        ae   <= ae_n;
      end
    end
  assign {p2_health, p1_health}       = hp;
  assign {p2_move_en, p1_move_en}     = me;
  assign {p2_attack_en, p1_attack_en} = ae;
  assign {p2_hit, p1_hit}             = hit;
  assign round_over                   = rs == R_OVER;
  assign winner                       = win;
endmodule

// File: tb/tb_combat_arbiter.sv
// tb_combat_arbiter: directed scenarios plus randomized frames against a frame-level combat model.
module tb_combat_arbiter;
  logic clk = 1'b0, reset = 1'b1, scen = 1'b0, rr = 1'b0;
  logic [9:0] x [2], y [2];
  logic fr [2], act [2], blk [2];
  logic [1:0] typ [2];
  logic p1_move_en, p2_move_en, p1_attack_en, p2_attack_en, p1_hit, p2_hit, round_over;
  logic [6:0] p1_health, p2_health;
  logic [1:0] winner;
  int m_hp [2], m_stun [2], m_win;
  bit m_done [2], m_blk [2], e_hit [2], m_over;
  int n_checks = 0, n_pass = 0;

  combat_arbiter dut (
    .clk(clk), .reset(reset), .SCEN(scen), .round_restart(rr),
    .p1_x(x[0]), .p2_x(x[1]), .p1_y(y[0]), .p2_y(y[1]),
    .p1_facing_right(fr[0]), .p2_facing_right(fr[1]),
    .p1_attack_active(act[0]), .p2_attack_active(act[1]),
    .p1_attack_type(typ[0]), .p2_attack_type(typ[1]),
    .p1_block(blk[0]), .p2_block(blk[1]),
    .p1_move_en(p1_move_en), .p2_move_en(p2_move_en),
    .p1_attack_en(p1_attack_en), .p2_attack_en(p2_attack_en),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_hit(p1_hit), .p2_hit(p2_hit),
    .round_over(round_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_hp = '{100, 100};
    m_stun = '{0, 0};
    m_done = '{0, 0};
    m_blk = '{0, 0};
    e_hit = '{0, 0};
    m_over = 0;
    m_win = 0;
  endtask

  function automatic bit in_reach(input int a);
    int ax, ay, ox, oy, r, lo, hi, dy;
    ax = int'(x[a]); ay = int'(y[a]); ox = int'(x[1-a]); oy = int'(y[1-a]);
    r  = (typ[a] == 2'd2) ? 60 : 30;
    lo = fr[a] ? ax + 60 : (ax > r ? ax - r : 0);
    hi = fr[a] ? ax + 60 + r : ax;
    dy = ay > oy ? ay - oy : oy - ay;
    return act[a] && (typ[a] == 2'd1 || typ[a] == 2'd2) && lo < ox + 60 && ox < hi && dy < 60;
  endfunction

  task automatic model_scen();
    bit v [2], b [2];
    int dm;
    if (m_over) begin
      e_hit = '{0, 0};
      if (rr) model_reset();
      return;
    end
    for (int a = 0; a < 2; a++)
      v[a] = in_reach(a) && m_stun[a] == 0 && m_stun[1-a] == 0 && !m_done[a];
    for (int d = 0; d < 2; d++) begin
      b[d] = 0;
`ifdef COMBAT_BLOCK_EN
      b[d] = blk[d] && (fr[d] ? x[1-d] > x[d] : x[1-d] < x[d]);
`endif
      m_blk[d] = b[d] ? 1'b1 : 1'b0;
`ifdef COMBAT_BLOCK_EN
      m_blk[d] = blk[d];
`endif
      e_hit[d] = 0;
      if (v[1-d]) begin
        dm = typ[1-d] == 2'd2 ? 10 : 5;
        if (b[d]) dm = dm / 4 > 0 ? dm / 4 : 1;
        m_hp[d] = m_hp[d] > dm ? m_hp[d] - dm : 0;
        if (!b[d]) begin m_stun[d] = 20; e_hit[d] = 1; end
      end else if (m_stun[d] > 0) m_stun[d]--;
    end
    for (int a = 0; a < 2; a++) m_done[a] = act[a] ? (m_done[a] || v[a]) : 1'b0;
    if (m_hp[0] == 0 || m_hp[1] == 0) begin
      m_over = 1;
      m_win = (m_hp[1] == 0 ? 1 : 0) + (m_hp[0] == 0 ? 2 : 0);
    end
  endtask

  function automatic int exp_en(input int p, input bit mv);
    return (!m_over && m_stun[p] == 0 && !(mv && m_blk[p])) ? 1 : 0;
  endfunction

  task automatic check_all(input bit pulses);
    check("p1_health", p1_health, m_hp[0]);
    check("p2_health", p2_health, m_hp[1]);
    check("p1_move_en", p1_move_en, exp_en(0, 1));
    check("p2_move_en", p2_move_en, exp_en(1, 1));
    check("p1_attack_en", p1_attack_en, exp_en(0, 0));
    check("p2_attack_en", p2_attack_en, exp_en(1, 0));
    check("p1_hit", p1_hit, pulses ? int'(e_hit[0]) : 0);
    check("p2_hit", p2_hit, pulses ? int'(e_hit[1]) : 0);
    check("round_over", round_over, int'(m_over));
    check("winner", winner, m_win);
  endtask

  // SCEN cycle, then one idle cycle where outputs must hold and hit pulses must be gone
  task automatic frame();
    bit sv;
    @(negedge clk); scen = 1; model_scen();
    @(negedge clk); scen = 0; check_all(1);
    sv = rr; rr = ~rr;
    @(negedge clk); check_all(0); rr = sv;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 0;
    #1 model_reset(); check_all(0);
    @(negedge clk); reset = 1;
  endtask

  task automatic setp(input int p, input int px, input int py, input bit f, input bit a, input int t);
    x[p] = 10'(px); y[p] = 10'(py); fr[p] = f; act[p] = a; typ[p] = 2'(t); blk[p] = 0;
  endtask

  initial begin
    setp(0, 0, 0, 0, 0, 0); setp(1, 0, 0, 0, 0, 0);
    #1 reset = 0;
    #2 model_reset(); check_all(0);
    @(negedge clk); reset = 1;
    // single hit, stun length
    setp(0, 100, 300, 1, 1, 1); setp(1, 170, 300, 0, 0, 0);
    repeat (3) frame();
    check("s1_p2_health", p2_health, 95);
    act[0] = 0;
    repeat (17) frame();
    check("s1_stun_last", p2_move_en, 0);
    frame();
    check("s1_stun_end", p2_move_en, 1);
    // out of range, then long reach
    do_reset();
    setp(0, 100, 300, 1, 1, 1); setp(1, 200, 300, 0, 0, 0);
    frame();
    check("s2_miss", p2_health, 100);
    act[0] = 0; frame();
    act[0] = 1; typ[0] = 2; frame();
    check("s2_atk2", p2_health, 90);
    // trade
    do_reset();
    setp(0, 100, 300, 1, 1, 1); setp(1, 170, 300, 0, 1, 2);
    frame();
    check("s3_p1_health", p1_health, 90);
    check("s3_p2_health", p2_health, 95);
    // invulnerability in stun and one hit per activation
    do_reset();
    setp(0, 100, 300, 1, 1, 1); setp(1, 170, 300, 0, 0, 0);
    repeat (11) frame();
    act[0] = 0; frame();
    act[0] = 1; repeat (4) frame();
    check("s5_no_rehit", p2_health, 95);
    act[0] = 0; repeat (5) frame();
    act[0] = 1; frame();
    check("s5_second_hit", p2_health, 90);
    // KO and restart
    do_reset();
    setp(0, 100, 300, 1, 0, 2); setp(1, 170, 300, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      act[0] = 1; frame();
      act[0] = 0; repeat (20) frame();
    end
    check("s4_ko_health", p2_health, 0);
    check("s4_round_over", round_over, 1);
    check("s4_winner", winner, 1);
    check("s4_enable", p1_attack_en, 0);
    act[0] = 1; act[1] = 1; typ[1] = 1; frame();
    check("s4_frozen", p1_health, 100);
    rr = 1; frame(); rr = 0;
    check("s4_restart_hp", p2_health, 100);
    check("s4_restart_win", winner, 0);
    // reset during hitstun
    setp(0, 100, 300, 1, 0, 1); setp(1, 170, 300, 0, 0, 0);
    frame(); act[0] = 1; repeat (5) frame();
    do_reset();
    check("s6_reset_hp", p2_health, 100);
    check("s6_reset_en", p2_move_en, 1);
`ifdef COMBAT_BLOCK_EN
    setp(0, 100, 300, 1, 1, 2); setp(1, 170, 300, 0, 0, 0); blk[1] = 1;
    frame();
    check("blk_chip", p2_health, 98);
    check("blk_no_stun", p2_attack_en, 1);
    check("blk_move", p2_move_en, 0);
    blk[1] = 0;
`endif
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++) begin
        x[p] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 40)) : 10'($urandom_range(100, 260));
        y[p] = 10'($urandom_range(270, 350));
        fr[p] = $urandom_range(0, 1) == 1;
        act[p] = $urandom_range(0, 2) != 0;
        typ[p] = 2'($urandom_range(0, 3));
        blk[p] = $urandom_range(0, 3) == 0;
      end
      rr = $urandom_range(0, 1) == 1;
      frame();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/combat_arbiter.md
Name: combat_arbiter

Overview:
- Frame-rate controller sitting between the two player_move/player_attack pairs and the renderer.
- Each SCEN frame it resolves attack hitboxes against opponent hurtboxes and applies damage and hitstun.
- It grants or withholds per-player move_enable/attack_enable and detects round end.
- It is the only writer of player health.

Parameters:
- BOX_W, 60, player hurtbox width in pixels
- BOX_H, 60, player hurtbox height; vertical overlap window
- ATK1_RANGE, 30, attack type 1 reach in pixels
- ATK2_RANGE, 60, attack type 2 reach in pixels
- ATK1_DMG, 5, attack type 1 damage
- ATK2_DMG, 10, attack type 2 damage
- HEALTH_MAX, 100, starting health (fits 7 bits)
- HITSTUN_FRAMES, 20, frames a hit player is locked out

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- SCEN  in  1  one-cycle frame strobe; all state advances only on SCEN
- round_restart  in  1  sampled on SCEN; restarts the round from ROUND_OVER
- p1_x, p2_x  in  10  player left edge
- p1_y, p2_y  in  10  player top edge
- p1_facing_right, p2_facing_right  in  1  facing direction
- p1_attack_active, p2_attack_active  in  1  from player_attack
- p1_attack_type, p2_attack_type  in  2  1 = atk1, 2 = atk2; 0 and 3 deal no hit
- p1_block, p2_block  in  1  block request; used only with COMBAT_BLOCK_EN
- p1_move_en, p2_move_en  out  1  to player_move.move_enable
- p1_attack_en, p2_attack_en  out  1  to player_attack.attack_enable
- p1_health, p2_health  out  7  current health
- p1_hit, p2_hit  out  1  one-clk pulse when that player takes a hit
- round_over  out  1  high in ROUND_OVER
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw

Behaviour:
- Reset (reset=0, asynchronous):
  - health = HEALTH_MAX for both players.
  - Both players in ACTIVE; stun counters 0; hit_done latches 0.
  - All enables = 1; hit pulses = 0; round_over = 0; winner = 00.
- Hitbox geometry:
  - Facing right: [x+BOX_W, x+BOX_W+R). Facing left: [x-R, x).
  - R is ATK1_RANGE or ATK2_RANGE by attack type.
  - Arithmetic is 11-bit; an x-R underflow clamps to 0.
  - Hurtbox: [ox, ox+BOX_W) horizontally.
  - Vertical overlap: |y1-y2| < BOX_H.
  - Hit condition: intervals intersect AND attack_active AND type is 1 or 2.
- Per-player FSM: ACTIVE, HITSTUN, KO.
  - ACTIVE: move_en = attack_en = 1.
  - ACTIVE -> HITSTUN on a valid hit received; stun counter loads HITSTUN_FRAMES-1.
  - HITSTUN: both enables 0; counter decrements each SCEN; returns to ACTIVE on the SCEN where the counter is 0.
  - HITSTUN lasts exactly HITSTUN_FRAMES frames.
  - Any state -> KO when health reaches 0.
- Hit validity:
  - The attacker must be in ACTIVE.
  - The defender must be in ACTIVE; a defender in HITSTUN is invulnerable.
  - The attacker's hit_done latch must be 0. The latch sets on a valid hit and clears on the first SCEN where attack_active=0, so there is one hit per attack activation.
- Damage:
  - health_next = (health > dmg) ? health - dmg : 0, saturating.
- Timing:
  - Evaluation occurs on the SCEN cycle; every output is registered and changes on the clk edge where SCEN=1.
  - pX_hit pulses for that single clk.
- Simultaneous hits: when both are valid on the same SCEN, both are applied (trade) and both enter HITSTUN.
- Global FSM: FIGHT, ROUND_OVER.
  - FIGHT -> ROUND_OVER on the same edge any health becomes 0.
  - winner is 01 if only P2 reaches 0, 10 if only P1 reaches 0, 11 if both do.
  - ROUND_OVER: all enables 0, hits ignored, health frozen.
  - round_restart=1 on SCEN in ROUND_OVER reinitialises everything to reset values.
  - round_restart in FIGHT is ignored.
- SCEN=0: no state change regardless of other inputs.

Optional Feature:
- Macro: COMBAT_BLOCK_EN.
- Defined: a defender in ACTIVE with pX_block=1 and facing the attacker blocks the hit.
  - Damage is dmg>>2, minimum 1.
  - No HITSTUN is entered and pX_hit is not pulsed.
  - The attacker's hit_done is still set.
  - While pX_block=1 and ACTIVE, pX_move_en = 0.
- Undefined: pX_block inputs are ignored and the behaviour is exactly as above.

Decomposition:
- Package fighter_pkg holds:
  - BOX_W, BOX_H, ATK1/ATK2 range and damage, HEALTH_MAX, HITSTUN_FRAMES;
  - attack-type encodings ATK_NONE=0, ATK1=1, ATK2=2;
  - player-state and round-state encodings.
- Sub-module combat_hit_detect: combinational hitbox/hurtbox intersection with the range mux. It is instantiated twice, once for P1 on P2 and once for P2 on P1.

Test Plan:
1. P1 at x=100, y=300, facing right, type 1 active; P2 at x=170, y=300. Across three SCENs -> a single p2_hit, p2_health 95, P2 enables low for 20 frames, then high.
2. Same as scenario 1 with P2 at x=200 -> no hit. Type 2 with P2 at x=200 -> p2_health 90.
3. Both players attack each other in range on the same SCEN -> both health 95 or 90, both stunned, both hit pulses.
4. P2 at health 4 takes an atk1 -> p2_health 0 (saturated), round_over=1, winner=01, all enables 0. round_restart on SCEN -> health 100/100, winner=00.
5. P2 is hit again while in HITSTUN, and P1 holds attack_active across 10 frames -> no additional damage. Reassert attack after stun ends -> a second hit.
6. Assert reset mid-HITSTUN -> outputs return to reset values asynchronously. With COMBAT_BLOCK_EN, a blocked atk2 -> damage 2, no stun, no hit pulse.
